// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the 16-bit instruction format.
// The encoder and the decode FSM both use these, so they agree on where each field sits.
package instr_encoder_pkg;

    // Field positions inside the 16-bit instruction word
    localparam int OPHI_MSB  = 15;
    localparam int OPHI_LSB  = 12;
    localparam int RDEST_MSB = 11;
    localparam int RDEST_LSB = 8;
    localparam int MID_MSB   = 7;   // OPEXT (R-type) / IMMHI (I-type)
    localparam int MID_LSB   = 4;
    localparam int LOW_MSB   = 3;   // RSRC (R-type) / IMMLO (I-type)
    localparam int LOW_LSB   = 0;

    localparam logic [15:0] NOP_WORD_DEFAULT = 16'h0000;

    typedef enum logic {
        FMT_R = 1'b0,
        FMT_I = 1'b1
    } fmt_e;

    typedef struct packed {
        logic        legal;
        logic [15:0] word;
    } enc_result_t;

    // Packs the decoded fields into one instruction word.
    // An R-type needs a zero high opcode nibble, because a non-zero nibble is what marks an I-type.
    function automatic enc_result_t encode_fields(
        input logic [7:0] opcode,
        input logic [3:0] rdest,
        input logic [3:0] rsrc,
        input logic [7:0] imm,
        input fmt_e       fmt
    );
        enc_result_t r;
        r.word  = '0;
        r.legal = 1'b0;
        r.word[RDEST_MSB:RDEST_LSB] = rdest;
        if (fmt == FMT_I) begin
            r.word[OPHI_MSB:OPHI_LSB] = opcode[7:4];
            r.word[MID_MSB:MID_LSB]   = imm[7:4];
            r.word[LOW_MSB:LOW_LSB]   = imm[3:0];
            r.legal = (opcode[7:4] != 4'h0);
        end else begin
            r.word[OPHI_MSB:OPHI_LSB] = 4'h0;
            r.word[MID_MSB:MID_LSB]   = opcode[3:0];
            r.word[LOW_MSB:LOW_LSB]   = rsrc;
            r.legal = (opcode[7:4] == 4'h0);
        end
        return r;
    endfunction

endpackage

// File: rtl/instr_encoder_sync_fifo.sv
// Small synchronous FIFO that holds encoded instruction words.
// Pointers and count are reset. The storage array is not reset, because the count alone decides what is valid.
module instr_encoder_sync_fifo
    import instr_encoder_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             full;
    logic             empty;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push_i && !full;
    assign pop_ok  = pop_i && !empty;

    // Next occupancy: a push and a pop in the same cycle cancel out
    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers. The pointers are power-of-two wide, so they wrap on their own.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage write port
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_encoder.sv
// Producer end of the 16-bit instruction interface.
// It packs the field tuples, queues them in a FIFO, and hands the head word to the decode FSM one pc_en pulse at a time.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_opcode,
    input  logic [3:0]  in_rdest,
    input  logic [3:0]  in_rsrc,
    input  logic [7:0]  in_imm,
    input  logic        in_imm_sel,
    input  logic        pc_en,
    output logic [15:0] instr_set,
    output logic        instr_valid,
    output logic        enc_err,
    output logic [7:0]  stall_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] count;
    logic [15:0]   head_word;
    enc_result_t   enc;
    logic          accept;
    logic          push;
    logic          pop;
    logic          empty;
    logic          enc_err_q;
    logic          enc_err_d;
    logic [7:0]    stall_cnt_q;
    logic [7:0]    stall_cnt_d;

    assign enc    = encode_fields(in_opcode, in_rdest, in_rsrc, in_imm, fmt_e'(in_imm_sel));
    assign empty  = (count == '0);
    assign accept = in_valid && in_ready;
    assign push   = accept && enc.legal;
    assign pop    = pc_en && !empty;

    instr_encoder_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (enc.word),
        .rdata_o (head_word),
        .count_o (count)
    );

    // Next-state for the error pulse and the saturating stall counter
    always_comb begin
        enc_err_d   = accept && !enc.legal;
        stall_cnt_d = stall_cnt_q;
        if (pc_en && empty && (stall_cnt_q != 8'hFF)) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
        end
    end

    // Register the status outputs so the decoder sees clean, edge-aligned values
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enc_err_q   <= 1'b0;
            stall_cnt_q <= 8'h00;
        end else begin
            enc_err_q   <= enc_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign in_ready    = (count != CW'(DEPTH));
    assign instr_valid = !empty;
    assign instr_set   = empty ? NOP_WORD : head_word;
    assign enc_err     = enc_err_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder. A queue holds the words expected at the FIFO head, in order.
`timescale 1ns/1ps
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_opcode = '0;
    logic [3:0]  in_rdest = '0;
    logic [3:0]  in_rsrc = '0;
    logic [7:0]  in_imm = '0;
    logic        in_imm_sel = 1'b0;
    logic        pc_en = 1'b0;
    logic [15:0] instr_set;
    logic        instr_valid;
    logic        enc_err;
    logic [7:0]  stall_cnt;

    int testsRun = 0;
    int testsFailed = 0;
    int expStall = 0;
    logic [15:0] sbQ[$];

    instr_encoder dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_rdest    (in_rdest),
        .in_rsrc     (in_rsrc),
        .in_imm      (in_imm),
        .in_imm_sel  (in_imm_sel),
        .pc_en       (pc_en),
        .instr_set   (instr_set),
        .instr_valid (instr_valid),
        .enc_err     (enc_err),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    // Advance one clock edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference packing of a tuple into the instruction word
    function automatic logic [16:0] modelWord(input logic [7:0] op, input logic [3:0] rd,
                                              input logic [3:0] rs, input logic [7:0] imm,
                                              input logic sel);
        logic legal;
        logic [15:0] w;
        if (sel) begin
            legal = (op[7:4] != 0);
            w = {op[7:4], rd, imm};
        end else begin
            legal = (op[7:4] == 0);
            w = {4'h0, rd, op[3:0], rs};
        end
        return {legal, w};
    endfunction

    // Put a tuple on the input fields without touching in_valid
    task automatic setFields(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs,
                             input logic [7:0] imm, input logic sel);
        in_opcode = op;
        in_rdest = rd;
        in_rsrc = rs;
        in_imm = imm;
        in_imm_sel = sel;
    endtask

    task automatic applyStimulus(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs,
                                 input logic [7:0] imm, input logic sel);
        logic [16:0] m;
        setFields(op, rd, rs, imm, sel);
        in_valid = 1'b1;
        m = modelWord(op, rd, rs, imm, sel);
        tick();
        in_valid = 1'b0;
        if (m[16]) sbQ.push_back(m[15:0]);
    endtask

    task automatic pulsePc();
        pc_en = 1'b1;
        tick();
        pc_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        testsRun++;
        if (in_ready !== 1'b1 || instr_valid !== 1'b0 || instr_set !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: ready=%b valid=%b set=%h, required 1 0 0000", in_ready, instr_valid, instr_set);
        end
        testsRun++;
        if (stall_cnt !== 8'h00 || enc_err !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_status: stall=%h err=%b, required 00 0", stall_cnt, enc_err);
        end
        @(negedge clk);
        reset = 1'b1;
        expStall = 0;
        tick();
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            pulsePc();
            expStall++;
            tick();
            tick();
            testsRun++;
            if (stall_cnt !== 8'(expStall) || instr_valid !== 1'b0 || instr_set !== 16'h0000) begin
                testsFailed++;
                $display("[TB] FAIL stall_%0d: stall=%0d valid=%b set=%h, required %0d 0 0000", i, stall_cnt, instr_valid, instr_set, expStall);
            end
        end
    endtask

    task automatic test_rtype();
        logic [15:0] exp;
        applyStimulus(8'h05, 4'd3, 4'd1, 8'h00, 1'b0);
        exp = sbQ.pop_front();
        testsRun++;
        if (instr_valid !== 1'b1 || instr_set !== exp) begin
            testsFailed++;
            $display("[TB] FAIL rtype_word: valid=%b set=%h, required 1 %h", instr_valid, instr_set, exp);
        end
        pulsePc();
        testsRun++;
        if (instr_valid !== 1'b0 || instr_set !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL rtype_popped: valid=%b set=%h, required 0 0000", instr_valid, instr_set);
        end
    endtask

    task automatic test_itype();
        logic [15:0] exp;
        logic [15:0] imm16;
        applyStimulus(8'h50, 4'd2, 4'd9, 8'hF6, 1'b1);
        exp = sbQ.pop_front();
        testsRun++;
        if (instr_valid !== 1'b1 || instr_set !== exp) begin
            testsFailed++;
            $display("[TB] FAIL itype_word: valid=%b set=%h, required 1 %h", instr_valid, instr_set, exp);
        end
        imm16 = {{8{instr_set[7]}}, instr_set[7:0]};
        testsRun++;
        if (instr_set[11:8] !== 4'd2 || imm16 !== 16'hFFF6) begin
            testsFailed++;
            $display("[TB] FAIL itype_fields: rdest=%0d imm16=%h, required 2 FFF6", instr_set[11:8], imm16);
        end
        pulsePc();
        testsRun++;
        if (instr_valid !== 1'b0 || stall_cnt !== 8'(expStall)) begin
            testsFailed++;
            $display("[TB] FAIL itype_popped: valid=%b stall=%0d, required 0 %0d", instr_valid, stall_cnt, expStall);
        end
    endtask

    task automatic test_illegal();
        logic [7:0] ops [2];
        logic       sels [2];
        ops[0] = 8'h15; sels[0] = 1'b0;
        ops[1] = 8'h0A; sels[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            testsRun++;
            if (in_ready !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL illegal_ready_%0d: ready=%b, required 1", i, in_ready);
            end
            applyStimulus(ops[i], 4'd4, 4'd6, 8'h33, sels[i]);
            testsRun++;
            if (enc_err !== 1'b1 || instr_valid !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL illegal_pulse_%0d: err=%b valid=%b, required 1 0", i, enc_err, instr_valid);
            end
            tick();
            testsRun++;
            if (enc_err !== 1'b0 || instr_valid !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL illegal_after_%0d: err=%b valid=%b, required 0 0", i, enc_err, instr_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  op;
        logic [7:0]  imm;
        logic        sel;
        logic [16:0] m;
        logic [15:0] exp;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sel = i[0];
            op  = sel ? {4'(i + 1), 4'h7} : {4'h0, 4'(i + 8)};
            imm = 8'(8'h11 * i + 8'h80);
            setFields(op, 4'(i + 1), 4'(15 - i), imm, sel);
            m = modelWord(op, 4'(i + 1), 4'(15 - i), imm, sel);
            if (i < 4) begin
                tick();
                sbQ.push_back(m[15:0]);
            end
        end
        testsRun++;
        if (in_ready !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL full_ready: ready=%b, required 0", in_ready);
        end
        tick();
        testsRun++;
        if (in_ready !== 1'b0 || instr_set !== sbQ[0]) begin
            testsFailed++;
            $display("[TB] FAIL full_hold: ready=%b head=%h, required 0 %h", in_ready, instr_set, sbQ[0]);
        end
        pc_en = 1'b1;
        tick();
        pc_en = 1'b0;
        exp = sbQ.pop_front();
        testsRun++;
        if (in_ready !== 1'b1 || instr_set !== sbQ[0]) begin
            testsFailed++;
            $display("[TB] FAIL full_pop: ready=%b head=%h, required 1 %h (popped %h)", in_ready, instr_set, sbQ[0], exp);
        end
        tick();
        in_valid = 1'b0;
        sbQ.push_back(m[15:0]);
        for (int i = 0; i < 4; i++) begin
            exp = sbQ.pop_front();
            testsRun++;
            if (instr_valid !== 1'b1 || instr_set !== exp) begin
                testsFailed++;
                $display("[TB] FAIL drain_%0d: valid=%b set=%h, required 1 %h", i, instr_valid, instr_set, exp);
            end
            pulsePc();
        end
        testsRun++;
        if (instr_valid !== 1'b0 || stall_cnt !== 8'(expStall)) begin
            testsFailed++;
            $display("[TB] FAIL drain_empty: valid=%b stall=%0d, required 0 %0d", instr_valid, stall_cnt, expStall);
        end
    endtask

    task automatic test_mid_reset();
        logic [15:0] exp;
        applyStimulus(8'h03, 4'd1, 4'd2, 8'h00, 1'b0);
        applyStimulus(8'h7F, 4'd5, 4'd0, 8'h12, 1'b1);
        applyStimulus(8'h0C, 4'd9, 4'd8, 8'h00, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        sbQ.delete();
        expStall = 0;
        testsRun++;
        if (instr_valid !== 1'b0 || in_ready !== 1'b1 || stall_cnt !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL async_reset: valid=%b ready=%b stall=%0d, required 0 1 0", instr_valid, in_ready, stall_cnt);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        applyStimulus(8'h9E, 4'd7, 4'd0, 8'hA5, 1'b1);
        applyStimulus(8'h0B, 4'd6, 4'd3, 8'h00, 1'b0);
        for (int i = 0; i < 2; i++) begin
            exp = sbQ.pop_front();
            testsRun++;
            if (instr_valid !== 1'b1 || instr_set !== exp) begin
                testsFailed++;
                $display("[TB] FAIL post_reset_%0d: valid=%b set=%h, required 1 %h", i, instr_valid, instr_set, exp);
            end
            pulsePc();
        end
    endtask

    task automatic checkOutput();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    endtask

    initial begin
        test_reset();
        test_stall();
        test_rtype();
        test_itype();
        test_illegal();
        test_back_to_back();
        test_mid_reset();
        checkOutput();
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Producer end of the 16-bit instruction interface consumed by the fetch/decode/execute FSM.
- Accepts decoded instruction fields from a stimulus/loader source through a valid/ready handshake, packs them into the 16-bit instruction format, and buffers them in a small FIFO.
- Presents the FIFO head on instr_set. Pops one word per PC-enable pulse, so the next FETCH state latches the next instruction.

Parameters:
- DEPTH, 4, FIFO entries; must be a power of 2, at least 2.
- NOP_WORD, 16'h0000, word driven on instr_set while the FIFO is empty.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  field tuple valid
- in_ready  output  1  encoder can accept a tuple
- in_opcode  input  8  {op_hi[3:0], op_ext[3:0]}
- in_rdest  input  4  destination register
- in_rsrc  input  4  source register (R-type only)
- in_imm  input  8  immediate (I-type only)
- in_imm_sel  input  1  1 = I-type, 0 = R-type
- pc_en  input  1  advance strobe from the decode FSM (high in its EXECUTE state)
- instr_set  output  16  instruction word to the decode FSM
- instr_valid  output  1  instr_set holds a real FIFO entry
- enc_err  output  1  one-cycle pulse: the accepted tuple was illegal and dropped
- stall_cnt  output  8  count of pc_en pulses seen while the FIFO was empty

Behaviour:
- Reset (asynchronous, active-low): rd_ptr, wr_ptr and count clear to 0; enc_err=0; stall_cnt=0.
  - Outputs during reset: in_ready=1, instr_valid=0, instr_set=NOP_WORD.
  - FIFO contents are not cleared.
  - Reset mid-operation discards all queued words.
- Handshake:
  - in_ready = (count != DEPTH), combinational from registered count.
  - A transfer occurs on a rising edge where in_valid && in_ready.
  - A push is not allowed when full, even if a pop happens in the same cycle.
- R-type encoding (in_imm_sel=0): word = {4'h0, in_rdest, in_opcode[3:0], in_rsrc}.
  - Legal only if in_opcode[7:4]==0.
- I-type encoding (in_imm_sel=1): word = {in_opcode[7:4], in_rdest, in_imm[7:4], in_imm[3:0]}.
  - Legal only if in_opcode[7:4]!=0.
  - in_opcode[3:0] and in_rsrc are ignored.
- Illegal tuple: the transfer still completes (in_ready unaffected), nothing is enqueued, and enc_err pulses high for the following cycle.
- Output:
  - instr_set = mem[rd_ptr] when count>0, else NOP_WORD.
  - instr_valid = (count>0).
  - Both derive from registers only, so they are stable across the decoder's FETCH edge.
- Pop: on a rising edge with pc_en=1 and count>0, rd_ptr increments and wraps modulo DEPTH.
  - The new head is visible the cycle after the pc_en edge, which is the cycle the decoder is in FETCH.
- Empty with pc_en=1: no pop; stall_cnt increments, saturating at 8'hFF.
- Latency: a tuple accepted at edge N into an empty FIFO appears on instr_set after edge N, so it is fetched at edge N+1 at the earliest.
- Simultaneous legal push and pop with 0<count<DEPTH: both occur and count is unchanged.
- Simultaneous push and pop with count==0: the push occurs, there is no pop, and stall_cnt increments.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- No internal state machine beyond the FIFO. The encoder never drives timing; the decode FSM's pc_en is the sole consumer strobe.

Decomposition:
- Shared package: instruction field positions (OPHI 15:12, RDEST 11:8, OPEXT/IMMHI 7:4, RSRC/IMMLO 3:0), the NOP word constant, and an encode function with a legality flag. The same package serves the decode FSM so both ends agree on the format.
- One natural sub-module: sync_fifo (DEPTH x 16, push/pop, full/empty, count). The encoder wraps it with the packing logic, the error pulse and the stall counter.

Test Plan:
- Reset, then pc_en pulsed every 3 cycles with no input → instr_set=16'h0000, instr_valid=0, stall_cnt increments by 1 per pulse.
- Push R-type opcode 8'h05, rdest 3, rsrc 1 → instr_set=16'h0351 the next cycle; after pc_en, instr_valid=0.
- Push I-type opcode 8'h50, rdest 2, imm 8'hF6 → instr_set=16'h52F6; fields 2 and F6 decode back through the decode FSM as rdest=2, imm16=16'hFFF6.
- Illegal tuples: R-type opcode 8'h15 → enc_err pulses 1 cycle, count unchanged. I-type opcode 8'h0A → same.
- Push 5 legal tuples back-to-back with no pc_en → in_ready drops after the 4th. Then pc_en with in_valid held → the 5th tuple is accepted the following cycle, and all words emerge in order across pointer wrap.
- Assert reset low mid-stream with 3 words queued → instr_valid=0, in_ready=1, stall_cnt=0 immediately (asynchronously); subsequent pushes are output in order starting from the new first word.
